// File: rtl/custom_axi_ip_mc.sv
// custom_axi_ip_mc: multi-channel iterated compute job (pass / increment / add-step) with
// per-channel result registers. Define CUSTOM_AXI_IP_SAT_EN to saturate the accumulator on overflow.
package custom_axi_ip_mc_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } status_e;
endpackage

module custom_axi_ip_mc
  import custom_axi_ip_mc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int ITER_WIDTH = 8,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [CH_W-1:0]       ch_sel_i,
  input  logic [1:0]            mode_i,
  input  logic [DATA_WIDTH-1:0] op_data_i,
  input  logic [DATA_WIDTH-1:0] step_i,
  input  logic [ITER_WIDTH-1:0] iter_i,
  input  logic                  clear_i,
  input  logic [CH_W-1:0]       rd_sel_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic                  drop_o,
  output logic                  ovf_o,
  output status_e               status_o
);

  localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);
  localparam logic [1:0]    MODE_INC = 2'b01;
  localparam logic [1:0]    MODE_ADD = 2'b10;
  localparam logic [1:0]    MODE_ILL = 2'b11;

  status_e               state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] step_q, step_d;
  logic [ITER_WIDTH-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [1:0]            mode_q, mode_d;
  logic                  drop_q, drop_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] result_q [NUM_CH];
  logic [DATA_WIDTH-1:0] result_d [NUM_CH];
  logic [DATA_WIDTH:0]   sum;
  logic                  cmd_bad;

  function automatic logic [DATA_WIDTH-1:0] fit_acc(input logic [DATA_WIDTH:0] s);
`ifdef CUSTOM_AXI_IP_SAT_EN
    return s[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : s[DATA_WIDTH-1:0];
`else
    return s[DATA_WIDTH-1:0];
`endif
  endfunction

  // One-bit-wider sum so the carry out doubles as the overflow flag; pass mode never carries.
  always_comb begin
    case (mode_q)
      MODE_INC: sum = {1'b0, acc_q} + {{DATA_WIDTH{1'b0}}, 1'b1};
      MODE_ADD: sum = {1'b0, acc_q} + {1'b0, step_q};
      default:  sum = {1'b0, acc_q};
    endcase
  end

  assign cmd_bad = (mode_i == MODE_ILL) || (iter_i == '0) || ({1'b0, ch_sel_i} >= NUM_CH_L);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    ch_d     = ch_q;
    mode_d   = mode_q;
    result_d = result_q;
    // Clear first so that a set event later in this block wins in the same cycle.
    drop_d   = clear_i ? 1'b0 : drop_q;
    ovf_d    = clear_i ? 1'b0 : ovf_q;
    if (start_i && (state_q != ST_IDLE)) drop_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          ch_d   = ch_sel_i;
          mode_d = mode_i;
          step_d = step_i;
          if (cmd_bad) begin
            state_d = ST_ERROR;
          end else begin
            acc_d   = op_data_i;
            cnt_d   = iter_i;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        acc_d = fit_acc(sum);
        if (sum[DATA_WIDTH]) ovf_d = 1'b1;
        cnt_d = cnt_q - ITER_WIDTH'(1);
        if (cnt_q == ITER_WIDTH'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_q == CH_W'(i)) result_d[i] = acc_q;
        end
        state_d = ST_IDLE;
      end
      ST_ERROR: begin
        if (clear_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      ch_q    <= '0;
      mode_q  <= '0;
      drop_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) result_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
      ch_q     <= ch_d;
      mode_q   <= mode_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
    end
  end

  // Selects beyond NUM_CH fall through to zero.
  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel_i == CH_W'(i)) rd_data_o = result_q[i];
    end
  end

  assign done_o   = (state_q == ST_DONE);
  assign error_o  = (state_q == ST_ERROR);
  assign drop_o   = drop_q;
  assign ovf_o    = ovf_q;
  assign status_o = state_q;

endmodule

// File: tb/tb_custom_axi_ip_mc.sv
// Scoreboard bench for custom_axi_ip_mc: jobs push closed-form expected results, a monitor
// pops them on done_o and reads every channel back. Built with three channels so ch_sel=3 is out of range.
`timescale 1ns/1ps
module tb_custom_axi_ip_mc;
  import custom_axi_ip_mc_pkg::*;

  localparam int DW   = 32;
  localparam int NCH  = 3;
  localparam int IW   = 8;
  localparam int CHW  = 2;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            start_i = 1'b0;
  logic [CHW-1:0]  ch_sel_i = '0;
  logic [1:0]      mode_i = '0;
  logic [DW-1:0]   op_data_i = '0;
  logic [DW-1:0]   step_i = '0;
  logic [IW-1:0]   iter_i = '0;
  logic            clear_i = 1'b0;
  logic [CHW-1:0]  rd_sel_i = '0;
  logic [DW-1:0]   rd_data_o;
  logic            done_o, error_o, drop_o, ovf_o;
  status_e         status_o;

  custom_axi_ip_mc #(.DATA_WIDTH(DW), .NUM_CH(NCH), .ITER_WIDTH(IW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .ch_sel_i(ch_sel_i),
    .mode_i(mode_i), .op_data_i(op_data_i), .step_i(step_i), .iter_i(iter_i),
    .clear_i(clear_i), .rd_sel_i(rd_sel_i), .rd_data_o(rd_data_o), .done_o(done_o),
    .error_o(error_o), .drop_o(drop_o), .ovf_o(ovf_o), .status_o(status_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  ch;
    logic [31:0] val;
    int          t0;
    int          iter;
  } sb_t;

  sb_t         sb_q[$];
  logic [31:0] exp_res [NCH];
  int          cyc = 0;
  int          chk_cnt = 0;
  int          total = 0;
  int          bad = 0;
  bit          drop_m = 0;
  bit          ovf_m = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: owns rd_sel_i and the expected result array.
  initial begin
    int  seen;
    bit  rb;
    sb_t e;
    seen = 0;
    rb = 0;
    for (int i = 0; i < NCH; i++) exp_res[i] = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        for (int i = 0; i < NCH; i++) exp_res[i] = '0;
      end
      if (done_o) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("done_latency", 64'(cyc - e.t0), 64'(e.iter + 1));
          exp_res[e.ch] = e.val;
          rb = 1;
        end
      end else if (rb || seen != chk_cnt) begin
        seen = chk_cnt;
        rb = 0;
        for (int i = 0; i < 4; i++) begin
          rd_sel_i = 2'(i);
          #1;
          if (i < NCH) check($sformatf("rd_ch%0d", i), rd_data_o, exp_res[i]);
          else         check($sformatf("rd_ch%0d_oob", i), rd_data_o, 0);
        end
      end
    end
  end

  // Issues one command from just after a clock edge and follows it until IDLE or ERROR.
  task automatic run_job(input logic [1:0] ch, input logic [1:0] mode, input logic [31:0] data,
                         input logic [31:0] step, input logic [7:0] iter, input bit poke);
    bit          legal, ov;
    logic [63:0] exact;
    logic [31:0] v;
    legal = (mode != 2'b11) && (iter != 0) && (ch < NCH);
    case (mode)
      2'b01:   exact = 64'(data) + 64'(iter);
      2'b10:   exact = 64'(data) + 64'(iter) * 64'(step);
      default: exact = 64'(data);
    endcase
    ov = exact > 64'hFFFF_FFFF;
`ifdef CUSTOM_AXI_IP_SAT_EN
    v = ov ? 32'hFFFF_FFFF : exact[31:0];
`else
    v = exact[31:0];
`endif
    ch_sel_i = ch; mode_i = mode; op_data_i = data; step_i = step; iter_i = iter;
    start_i = 1'b1;
    if (legal) sb_q.push_back('{ch, v, cyc, int'(iter)});
    tick();
    start_i = 1'b0;
    if (!legal) begin
      check("err_state", status_o, ST_ERROR);
      check("err_flag", error_o, 1);
      return;
    end
    for (int k = 1; k <= int'(iter); k++) begin
      check("busy_state", status_o, ST_BUSY);
      start_i = poke && (k == 1);
      tick();
    end
    start_i = 1'b0;
    if (poke) drop_m = 1;
    if (ov) ovf_m = 1;
    check("done_state", status_o, ST_DONE);
    check("done_pulse", done_o, 1);
    tick();
    check("idle_after", status_o, ST_IDLE);
    check("done_low", done_o, 0);
    check("ovf_sticky", ovf_o, ovf_m);
    check("drop_sticky", drop_o, drop_m);
  endtask

  task automatic clear_err(input bit with_start);
    clear_i = 1'b1;
    start_i = with_start;
    tick();
    clear_i = 1'b0;
    start_i = 1'b0;
    drop_m = with_start;
    ovf_m = 0;
    check("clr_state", status_o, ST_IDLE);
    check("clr_err", error_o, 0);
    check("clr_drop", drop_o, drop_m);
    check("clr_ovf", ovf_o, 0);
  endtask

  task automatic clear_idle();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    drop_m = 0;
    ovf_m = 0;
    check("clri_state", status_o, ST_IDLE);
    check("clri_drop", drop_o, 0);
    check("clri_ovf", ovf_o, 0);
  endtask

  task automatic readback();
    chk_cnt++;
    tick();
    tick();
  endtask

  initial begin
    logic [1:0]  rch, rmode;
    logic [31:0] rdata, rstep;
    logic [7:0]  riter;

    repeat (3) tick();
    check("rst_state", status_o, ST_IDLE);
    check("rst_flags", {done_o, error_o, drop_o, ovf_o}, 0);
    rst_ni = 1'b1;
    tick();
    check("post_rst_state", status_o, ST_IDLE);
    check("post_rst_flags", {done_o, error_o, drop_o, ovf_o}, 0);
    readback();

    run_job(2'd2, 2'b01, 32'h10, 32'h0, 8'd3, 1'b0);
    run_job(2'd1, 2'b10, 32'hFFFF_FFF0, 32'h20, 8'd1, 1'b0);
    clear_idle();

    run_job(2'd0, 2'b11, 32'h55, 32'h1, 8'd2, 1'b0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    drop_m = 1;
    check("err_start_drop", drop_o, 1);
    check("err_hold", status_o, ST_ERROR);
    clear_err(1'b0);

    run_job(2'd0, 2'b01, 32'h77, 32'h1, 8'd0, 1'b0);
    clear_err(1'b1);
    run_job(2'd3, 2'b00, 32'h99, 32'h1, 8'd2, 1'b0);
    clear_err(1'b0);
    readback();

    run_job(2'd0, 2'b10, 32'h100, 32'h3, 8'd4, 1'b1);
    clear_idle();

    // Abort a job by reset in its fourth BUSY cycle.
    ch_sel_i = 2'd0; mode_i = 2'b01; op_data_i = 32'h1234; iter_i = 8'd10;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (3) tick();
    check("busy_before_rst", status_o, ST_BUSY);
    rst_ni = 1'b0;
    #1;
    check("abort_state", status_o, ST_IDLE);
    check("abort_flags", {done_o, error_o, drop_o, ovf_o}, 0);
    drop_m = 0;
    ovf_m = 0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    readback();
    run_job(2'd0, 2'b01, 32'h20, 32'h0, 8'd2, 1'b0);

    for (int n = 0; n < 40; n++) begin
      rch   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      rmode = 2'($urandom_range(0, 3));
      rdata = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 20) : $urandom;
      rstep = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) : $urandom;
      riter = 8'($urandom_range(0, 12));
      run_job(rch, rmode, rdata, rstep, riter, $urandom_range(0, 4) == 0);
      if (status_o == ST_ERROR) clear_err(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 5) == 0) clear_idle();
    end

    readback();
    repeat (2) tick();
    check("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
